// File: rtl/seg_scan_driver.sv
// seg_scan_driver
// Two-digit multiplexed 7-segment scanner with an anti-ghost blank gap
// between digits and frame-synchronous (tear-free) data update.
//
// Ports
//   clk        system clock, all state on rising edge
//   rst        synchronous active-high reset
//   inOne      BCD ones digit, captured into pending when load=1
//   inTen      BCD tens digit, captured into pending when load=1
//   load       single-cycle strobe requesting display of inOne/inTen
//   blankZero  level: suppress a displayed tens digit of 0
//   ack        1-cycle pulse, aligned with the first displayed DIG0 of new data
//   seg        segments {g,f,e,d,c,b,a}, active-low, registered
//   an         digit enables, active-low, registered; an[0]=ones, an[1]=tens
module seg_scan_driver #(
    parameter int DWELL = 50000,
    parameter int GAP   = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] inOne,
    input  logic [3:0] inTen,
    input  logic       load,
    input  logic       blankZero,
    output logic       ack,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int MAXD = (DWELL > GAP) ? DWELL : GAP;
    localparam int CW   = $clog2(MAXD + 1);

    typedef enum logic [1:0] {
        DIG0   = 2'd0,
        BLANK0 = 2'd1,
        DIG1   = 2'd2,
        BLANK1 = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    one_act_q, one_act_d;
    logic [3:0]    ten_act_q, ten_act_d;
    logic [3:0]    one_pend_q, one_pend_d;
    logic [3:0]    ten_pend_q, ten_pend_d;
    logic          pend_q, pend_d;
    logic          xfer_q, xfer_d;
    logic          ack_q, ack_d;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    an_q, an_d;
    logic          last_cycle;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        one_act_d  = one_act_q;
        ten_act_d  = ten_act_q;
        one_pend_d = one_pend_q;
        ten_pend_d = ten_pend_q;
        pend_d     = pend_q;
        xfer_d     = 1'b0;
        seg_d      = 7'h7F;
        an_d       = 2'b11;

        // Counter holds the cycles remaining in the current state, so the
        // final cycle is cnt==1 and the reload happens on that same edge.
        last_cycle = (cnt_q == CW'(1));
        if (last_cycle) begin
            case (state_q)
                DIG0:    begin state_d = BLANK0; cnt_d = CW'(GAP);   end
                BLANK0:  begin state_d = DIG1;   cnt_d = CW'(DWELL); end
                DIG1:    begin state_d = BLANK1; cnt_d = CW'(GAP);   end
                default: begin state_d = DIG0;   cnt_d = CW'(DWELL); end
            endcase
        end else begin
            cnt_d = cnt_q - CW'(1);
        end

        // Frame boundary transfer; it uses the pending data as it stood
        // before this cycle's load, and a coincident load re-arms pending.
        if (state_q == BLANK1 && last_cycle && pend_q) begin
            one_act_d = one_pend_q;
            ten_act_d = ten_pend_q;
            pend_d    = 1'b0;
            xfer_d    = 1'b1;
        end
        if (load) begin
            one_pend_d = inOne;
            ten_pend_d = inTen;
            pend_d     = 1'b1;
        end

        // Outputs registered from the current state and active digits.
        case (state_q)
            DIG0: begin
                an_d  = 2'b10;
                seg_d = decode(one_act_q);
            end
            DIG1: begin
                if (!(blankZero && ten_act_q == 4'd0)) begin
                    an_d  = 2'b01;
                    seg_d = decode(ten_act_q);
                end
            end
            default: ;
        endcase

        // Delayed one cycle so ack lines up with the first registered DIG0.
        ack_d = xfer_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BLANK1;
            cnt_q      <= CW'(GAP);
            one_act_q  <= 4'd0;
            ten_act_q  <= 4'd0;
            one_pend_q <= 4'd0;
            ten_pend_q <= 4'd0;
            pend_q     <= 1'b0;
            xfer_q     <= 1'b0;
            ack_q      <= 1'b0;
            seg_q      <= 7'h7F;
            an_q       <= 2'b11;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            one_act_q  <= one_act_d;
            ten_act_q  <= ten_act_d;
            one_pend_q <= one_pend_d;
            ten_pend_q <= ten_pend_d;
            pend_q     <= pend_d;
            xfer_q     <= xfer_d;
            ack_q      <= ack_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign ack = ack_q;
    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Testbench for seg_scan_driver with DWELL=4, GAP=2 (12-cycle frame).
// The reference model tracks the position within the frame (0..11) and the
// active/pending digits; expected outputs follow from that position.
module tb_seg_scan_driver;

    localparam int DWELL = 4;
    localparam int GAP   = 2;
    localparam int FRAME = 2 * (DWELL + GAP);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] inOne = 4'd0;
    logic [3:0] inTen = 4'd0;
    logic       load = 1'b0;
    logic       blankZero = 1'b0;
    logic       ack;
    logic [6:0] seg;
    logic [1:0] an;

    int tests_run = 0;
    int tests_failed = 0;

    seg_scan_driver #(.DWELL(DWELL), .GAP(GAP)) dut (
        .clk(clk), .rst(rst), .inOne(inOne), .inTen(inTen), .load(load),
        .blankZero(blankZero), .ack(ack), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [6:0] dec_tab [0:15];
    int         m_pos;
    logic [3:0] m_one, m_ten, m_pone, m_pten;
    logic       m_pflag, m_xfer;
    logic [6:0] exp_seg;
    logic [1:0] exp_an;
    logic       exp_ack;

    // Advance model and DUT by one clock with the given inputs.
    task automatic cyc(input logic r, input logic ld, input logic [3:0] o,
                       input logic [3:0] t, input logic bz);
        rst = r; load = ld; inOne = o; inTen = t; blankZero = bz;
        if (ld && !r) $display("[TB] load ones=%0d tens=%0d at pos %0d", o, t, m_pos);
        if (r) begin
            m_pos = FRAME - GAP;
            m_one = 0; m_ten = 0; m_pone = 0; m_pten = 0;
            m_pflag = 0; m_xfer = 0;
            exp_an = 2'b11; exp_seg = 7'h7F; exp_ack = 1'b0;
        end else begin
            exp_an = 2'b11; exp_seg = 7'h7F;
            if (m_pos < DWELL) begin
                exp_an = 2'b10; exp_seg = dec_tab[m_one];
            end else if (m_pos >= DWELL + GAP && m_pos < 2 * DWELL + GAP) begin
                if (!(bz && m_ten == 0)) begin
                    exp_an = 2'b01; exp_seg = dec_tab[m_ten];
                end
            end
            exp_ack = m_xfer;
            m_xfer = 0;
            if (m_pos == FRAME - 1 && m_pflag) begin
                m_one = m_pone; m_ten = m_pten; m_pflag = 0; m_xfer = 1;
            end
            if (ld) begin
                m_pone = o; m_pten = t; m_pflag = 1;
            end
            m_pos = (m_pos + 1) % FRAME;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic goto_pos(input int p);
        for (int i = 0; i < FRAME && m_pos != p; i++) cyc(0, 0, 0, 0, blankZero);
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 4'd5, 4'd5, 0);
        tests_run++;
        if (an !== 2'b11 || seg !== 7'h7F || ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset: an=%b seg=%h ack=%b, required an=11 seg=7f ack=0", an, seg, ack);
        end
        for (int i = 0; i < GAP; i++) begin
            cyc(0, 0, 0, 0, 0);
            tests_run++;
            if (an !== 2'b11 || seg !== 7'h7F) begin
                tests_failed++;
                $display("FAIL reset_gap[%0d]: an=%b seg=%h, required an=11 seg=7f", i, an, seg);
            end
        end
        cyc(0, 0, 0, 0, 0);
        tests_run++;
        if (an !== 2'b10 || seg !== 7'h40 || ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL first_dig0: an=%b seg=%h ack=%b, required an=10 seg=40 ack=0", an, seg, ack);
        end
    endtask

    task automatic test_idle();
        int acks = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            cyc(0, 0, 0, 0, 0);
            acks += int'(ack);
            tests_run++;
            if (an !== exp_an || seg !== exp_seg || ack !== exp_ack) begin
                tests_failed++;
                $display("FAIL idle[%0d]: an=%b seg=%h ack=%b, required an=%b seg=%h ack=%b",
                         i, an, seg, ack, exp_an, exp_seg, exp_ack);
            end
        end
        tests_run++;
        if (acks != 0) begin
            tests_failed++;
            $display("FAIL idle_acks: got %0d, required 0", acks);
        end
    endtask

    // Loads at the given frame positions, then runs and counts acks.
    task automatic test_loads(input string name, input int n, input int pos_a [3],
                              input logic [3:0] one_a [3], input logic [3:0] ten_a [3],
                              input logic bz, input int frames, input int want_acks);
        int acks = 0;
        for (int k = 0; k < n; k++) begin
            goto_pos(pos_a[k]);
            cyc(0, 1, one_a[k], ten_a[k], bz);
            acks += int'(ack);
        end
        for (int i = 0; i < frames * FRAME; i++) begin
            cyc(0, 0, 0, 0, bz);
            acks += int'(ack);
            tests_run++;
            if (an !== exp_an || seg !== exp_seg || ack !== exp_ack) begin
                tests_failed++;
                $display("FAIL %s[%0d]: an=%b seg=%h ack=%b, required an=%b seg=%h ack=%b",
                         name, i, an, seg, ack, exp_an, exp_seg, exp_ack);
            end
        end
        tests_run++;
        if (acks != want_acks) begin
            tests_failed++;
            $display("FAIL %s_acks: got %0d, required %0d", name, acks, want_acks);
        end
    endtask

    task automatic test_load_basic();
        int         p [3] = '{7, 0, 0};
        logic [3:0] o [3] = '{4'd7, 4'd0, 4'd0};
        logic [3:0] t [3] = '{4'd3, 4'd0, 4'd0};
        test_loads("load_basic", 1, p, o, t, 0, 3, 1);
        // Next DIG0 of this frame must show the ones digit 7 = 78.
        goto_pos(0);
        cyc(0, 0, 0, 0, 0);
        tests_run++;
        if (an !== 2'b10 || seg !== 7'h78) begin
            tests_failed++;
            $display("FAIL load_basic_dig0: an=%b seg=%h, required an=10 seg=78", an, seg);
        end
    endtask

    task automatic test_multi_load();
        int         p [3] = '{1, 3, 5};
        logic [3:0] o [3] = '{4'd1, 4'd2, 4'd5};
        logic [3:0] t [3] = '{4'd1, 4'd2, 4'd4};
        test_loads("multi_load", 3, p, o, t, 0, 2, 1);
    endtask

    task automatic test_blank_zero();
        int         p [3] = '{2, 0, 0};
        logic [3:0] o [3] = '{4'd9, 4'd0, 4'd0};
        logic [3:0] t [3] = '{4'd0, 4'd0, 4'd0};
        test_loads("blank_zero", 1, p, o, t, 1, 3, 1);
        goto_pos(DWELL + GAP + 1);
        cyc(0, 0, 0, 0, 1);
        tests_run++;
        if (an !== 2'b11 || seg !== 7'h7F) begin
            tests_failed++;
            $display("FAIL blank_zero_dig1: an=%b seg=%h, required an=11 seg=7f", an, seg);
        end
    endtask

    task automatic test_dash();
        int         p [3] = '{4, 0, 0};
        logic [3:0] o [3] = '{4'd12, 4'd0, 4'd0};
        logic [3:0] t [3] = '{4'd15, 4'd0, 4'd0};
        test_loads("dash", 1, p, o, t, 0, 2, 1);
    endtask

    task automatic test_boundary_load();
        int         p [3] = '{3, FRAME - 1, 0};
        logic [3:0] o [3] = '{4'd4, 4'd8, 4'd0};
        logic [3:0] t [3] = '{4'd2, 4'd6, 4'd0};
        test_loads("boundary_load", 2, p, o, t, 0, 3, 2);
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        goto_pos(5);
        cyc(0, 1, 4'd5, 4'd5, 0);
        goto_pos(2);
        cyc(1, 0, 0, 0, 0);
        tests_run++;
        if (an !== 2'b11 || seg !== 7'h7F || ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid: an=%b seg=%h ack=%b, required an=11 seg=7f ack=0", an, seg, ack);
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            cyc(0, 0, 0, 0, 0);
            acks += int'(ack);
            tests_run++;
            if (an !== exp_an || seg !== exp_seg || ack !== exp_ack) begin
                tests_failed++;
                $display("FAIL reset_mid[%0d]: an=%b seg=%h ack=%b, required an=%b seg=%h ack=%b",
                         i, an, seg, ack, exp_an, exp_seg, exp_ack);
            end
        end
        tests_run++;
        if (acks != 0) begin
            tests_failed++;
            $display("FAIL reset_mid_acks: got %0d, required 0", acks);
        end
    endtask

    task automatic test_random();
        logic bz = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 29) == 0) bz = ~bz;
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), bz);
            tests_run++;
            if (an !== exp_an || seg !== exp_seg || ack !== exp_ack) begin
                tests_failed++;
                $display("FAIL random[%0d]: an=%b seg=%h ack=%b, required an=%b seg=%h ack=%b",
                         i, an, seg, ack, exp_an, exp_seg, exp_ack);
            end
        end
    endtask

    initial begin
        dec_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        m_pos = 0; m_one = 0; m_ten = 0; m_pone = 0; m_pten = 0;
        m_pflag = 0; m_xfer = 0;
        exp_an = 2'b11; exp_seg = 7'h7F; exp_ack = 1'b0;
        test_reset();
        test_idle();
        test_load_basic();
        test_multi_load();
        test_blank_zero();
        test_dash();
        test_boundary_load();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
